// File: rtl/counter_pkg.sv
// Shared encodings for the counter/timer block.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/counter_prescaler.sv
// Tick generator: counts 0..div and emits a one-cycle tick on the last count.
// clr holds the phase at zero; ena low freezes the phase in place.
module counter_prescaler #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clr,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] pre;

  assign tick = ena & ~clr & (pre == div);

  // Prescaler phase counter, wrapping to zero on each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (ena) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/counter_timer.sv
// Programmable counter/timer: prescaled up/down count with free-run,
// one-shot and periodic reload modes and a registered terminal-count pulse.
//
// state | meaning
// IDLE  | after reset or clr, not counting, out=0
// RUN   | counting on prescaler ticks, out=1
// DONE  | one-shot expired, cnt holds terminal value, out=0
module counter_timer
  import counter_pkg::*;
#(
  parameter int CW = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clr,
  input  logic          ld,
  input  logic [1:0]    mode,
  input  logic          dir,
  input  logic [CW-1:0] lim,
  input  logic [PW-1:0] div,
  output logic [CW-1:0] cnt,
  output logic          out,
  output logic          tc
);

  state_t        state;
  mode_t         mode_q;
  logic          dir_q;
  logic [CW-1:0] lim_q;
  logic [PW-1:0] div_q;

  logic          tick;
  logic          pre_clr;
  logic [CW-1:0] term_val;
  logic [CW-1:0] start_val;
  logic [CW-1:0] step_val;

  // Configuration only takes effect through the shadow copies taken at ld.
  assign term_val  = dir_q ? lim_q : '0;
  assign start_val = dir_q ? '0 : lim_q;
  assign step_val  = dir_q ? cnt + 1'b1 : cnt - 1'b1;

  // Prescaler restarts from phase zero on every load and idles outside RUN.
  assign pre_clr = clr | ld | (state != RUN);

  counter_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .clr  (pre_clr),
    .div  (div_q),
    .tick (tick)
  );

  // Timer FSM with registered count, status and terminal-count pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      out    <= 1'b0;
      tc     <= 1'b0;
      mode_q <= MODE_FREE;
      dir_q  <= 1'b0;
      lim_q  <= '0;
      div_q  <= '0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        state <= IDLE;
        cnt   <= '0;
        out   <= 1'b0;
      end else if (ld) begin
        mode_q <= mode_t'(mode);
        dir_q  <= dir;
        lim_q  <= lim;
        div_q  <= div;
        cnt    <= dir ? '0 : lim;
        state  <= RUN;
        out    <= 1'b1;
      end else if (tick) begin
        if (cnt == term_val) begin
          tc <= 1'b1;
          case (mode_q)
            MODE_ONESHOT: begin
              state <= DONE;
              out   <= 1'b0;
            end
            MODE_PERIODIC: cnt <= start_val;
            default:       cnt <= step_val;
          endcase
        end else begin
          cnt <= step_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_timer.sv
// Directed and randomized bench for counter_timer against a cycle-level
// arithmetic reference model.
module tb_counter_timer;

  localparam int CW  = 3;
  localparam int PW  = 4;
  localparam int MOD = 1 << CW;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic          ena  = 1'b0;
  logic          clr  = 1'b0;
  logic          ld   = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          dir  = 1'b0;
  logic [CW-1:0] lim  = '0;
  logic [PW-1:0] div  = '0;
  logic [CW-1:0] cnt;
  logic          out;
  logic          tc;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_cnt, m_pre, m_tc;
  int s_mode, s_dir, s_lim, s_div;
  bit m_run;

  counter_timer #(.CW(CW), .PW(PW)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .clr  (clr),
    .ld   (ld),
    .mode (mode),
    .dir  (dir),
    .lim  (lim),
    .div  (div),
    .cnt  (cnt),
    .out  (out),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_tc = 0; m_run = 0;
    s_mode = 0; s_dir = 0; s_lim = 0; s_div = 0;
  endtask

  task automatic model_edge();
    int term;
    m_tc = 0;
    if (clr) begin
      m_cnt = 0; m_pre = 0; m_run = 0;
    end else if (ld) begin
      s_mode = int'(mode); s_dir = int'(dir); s_lim = int'(lim); s_div = int'(div);
      m_cnt = dir ? 0 : int'(lim);
      m_pre = 0;
      m_run = 1;
    end else if (m_run && ena) begin
      if (m_pre != s_div) begin
        m_pre++;
      end else begin
        m_pre = 0;
        term = s_dir ? s_lim : 0;
        if (m_cnt == term) begin
          m_tc = 1;
          if (s_mode == 1)      m_run = 0;
          else if (s_mode == 2) m_cnt = s_dir ? 0 : s_lim;
          else                  m_cnt = (m_cnt + (s_dir ? 1 : MOD - 1)) % MOD;
        end else begin
          m_cnt = (m_cnt + (s_dir ? 1 : MOD - 1)) % MOD;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("out", 32'(out), 32'(m_run));
    chk("tc",  32'(tc),  32'(m_tc));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_edge();
      #1;
      compare_model();
    end
  endtask

  task automatic start(input logic [1:0] md, input logic d, input int l, input int dv);
    mode = md; dir = d; lim = CW'(l); div = PW'(dv);
    ld = 1'b1;
    step(1);
    ld = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    #1;
    chk("reset_cnt", 32'(cnt), 0);
    chk("reset_out", 32'(out), 0);
    chk("reset_tc",  32'(tc),  0);
    #1 rst = 1'b1;
    ena = 1'b1;
    step(2);
    chk("idle_no_ld", 32'(out), 0);

    // periodic up, lim=5, div=0
    start(2'b10, 1'b1, 5, 0);
    chk("ld_start_cnt", 32'(cnt), 0);
    chk("ld_start_out", 32'(out), 1);
    step(14);

    // reset asserted between edges mid-run
    start(2'b10, 1'b1, 5, 0);
    step(4);
    chk("pre_rst_cnt", 32'(cnt), 4);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_cnt", 32'(cnt), 0);
    chk("rst_mid_out", 32'(out), 0);
    chk("rst_mid_tc",  32'(tc),  0);
    #1 rst = 1'b1;
    step(5);
    chk("idle_after_rst", 32'(out), 0);

    // one-shot down, lim=3, div=1, then retrigger
    start(2'b01, 1'b0, 3, 1);
    step(10);
    chk("oneshot_hold_cnt", 32'(cnt), 0);
    chk("oneshot_done_out", 32'(out), 0);
    start(2'b01, 1'b0, 3, 1);
    chk("retrigger_cnt", 32'(cnt), 3);
    step(3);

    // freeze mid tick period
    start(2'b10, 1'b1, 7, 2);
    step(4);
    ena = 1'b0;
    step(4);
    ena = 1'b1;
    step(10);

    // clr and ld together: clr wins
    clr = 1'b1; ld = 1'b1;
    step(1);
    clr = 1'b0; ld = 1'b0;
    chk("clr_ld_cnt", 32'(cnt), 0);
    chk("clr_ld_out", 32'(out), 0);
    step(2);

    // shadowing: lim change during RUN ignored
    start(2'b10, 1'b1, 5, 0);
    lim = 3'd2;
    step(14);

    // free-run up with wrap, then reserved mode counting down
    start(2'b00, 1'b1, 2, 0);
    step(20);
    start(2'b11, 1'b0, 1, 1);
    step(20);

    // lim=0 up periodic: terminal every tick
    start(2'b10, 1'b1, 0, 0);
    step(5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r    = int'($urandom_range(0, 99));
      ld   = (r < 6) || (r == 9);
      clr  = (r >= 7) && (r <= 9);
      ena  = ($urandom_range(0, 9) != 0);
      mode = 2'($urandom_range(0, 3));
      dir  = 1'($urandom_range(0, 1));
      lim  = CW'($urandom_range(0, MOD - 1));
      div  = PW'($urandom_range(0, 3));
      step(1);
    end
    ld = 1'b0; clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_timer.md
Name: counter_timer

Overview:
Parametrised successor to the basic enabled/clearable counter. Adds a programmable prescaler, up/down direction, a loadable limit, and three run modes: free-run, one-shot and periodic auto-reload. It also provides a registered terminal-count pulse.
Used as the generic timebase for bus timing slots and timeouts in the 1-wire master.

Parameters:
CW, 8, counter width in bits
PW, 4, prescaler width in bits; tick period is div+1 clock cycles

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
ena  input  1  enable; 0 freezes prescaler and counter
clr  input  1  synchronous clear
ld   input  1  load/start pulse; samples configuration and starts the timer
mode input  2  00 free-run, 01 one-shot, 10 periodic, 11 reserved (behaves as free-run)
dir  input  1  1 = count up, 0 = count down
lim  input  CW limit value: terminal value when counting up, start value when counting down
div  input  PW prescaler divide value
cnt  output CW current count
out  output 1  running status
tc   output 1  terminal-count pulse, one cycle wide

Behaviour:
- Reset (rst=0, asynchronous):
  - cnt=0, out=0, tc=0, prescaler=0, state IDLE.
  - Shadow registers (mode, dir, lim, div) cleared.
- Priority at each clock edge: clr > ld > counting (ena-gated). clr and ld act regardless of ena.
- clr: cnt=0, prescaler=0, tc=0, state IDLE.
- ld: mode, dir, lim and div are captured into shadow registers.
  - Changes to these inputs after ld have no effect until the next ld.
- Start value after ld: cnt=0 if dir=1; cnt=lim if dir=0.
- Terminal value T: lim if dir=1; 0 if dir=0.
- After the ld edge: state RUN, prescaler=0.
- ld in any state (IDLE, RUN, DONE) restarts the timer (retrigger).
- States:
  - IDLE: out=0, no counting.
  - RUN: out=1.
  - DONE: one-shot expired, out=0, cnt holds T.
- Prescaler: counts 0..div while RUN and ena=1.
  - tick = RUN & ena & (prescaler==div); the prescaler wraps to 0 on tick.
  - div=0 gives a tick every cycle.
- Counting, at each tick:
  - cnt != T: cnt steps +1 (dir=1) or -1 (dir=0), modulo 2^CW.
  - cnt == T, free-run: cnt steps modulo 2^CW (no reload), tc=1.
  - cnt == T, periodic: cnt reloads the start value, tc=1.
  - cnt == T, one-shot: cnt holds T, tc=1, state goes to DONE.
- tc is registered. It is high exactly during the cycle following the terminal-tick edge, coincident with the reload or DONE update. Otherwise tc=0.
- Latency:
  - ld sampled at edge k: out=1 and cnt=start value after edge k.
  - First count change at edge k+div+1.
- Boundary cases:
  - lim=0, up: the first tick is terminal. In periodic mode tc fires every tick and cnt stays 0.
  - ena=0 mid-run: cnt, prescaler, state and tc=0 all frozen; the prescaler phase is preserved on resume.
  - Reset asserted mid-operation aborts immediately; there is no restart after reset release.
- Width rules: all counter arithmetic is CW bits, unsigned, wrapping. The prescaler is PW bits.

Decomposition:
- Shared package counter_pkg holds:
  - mode encodings (MODE_FREE=2'b00, MODE_ONESHOT=2'b01, MODE_PERIODIC=2'b10);
  - state encodings (IDLE, RUN, DONE).
- One sub-module: counter_prescaler
  - parameter PW;
  - ports clk, rst, ena, clr, div; output tick;
  - the parent drives its clr on clr | ld | ~RUN.

Test Plan:
- Reset mid-run: CW=3, periodic, cnt=4, drive rst=0 between edges -> cnt=0, out=0, tc=0 immediately; stays IDLE after release until ld.
- Periodic up: CW=3, lim=5, div=0, ld -> cnt 0,1,2,3,4,5,0,1..., tc high one cycle each time cnt returns to 0 (every 6 cycles), out=1 throughout.
- One-shot down: lim=3, div=1 -> each value 3,2,1,0 held 2 cycles; tc pulses once as the DONE update occurs; out falls to 0; cnt held at 0; a second ld restarts from 3.
- Freeze: periodic up, lim=7, div=2, ena=0 for 4 cycles mid-tick-period -> cnt and prescaler unchanged; after ena=1 the next tick arrives after the remaining prescaler cycles.
- Priority/shadowing: clr and ld in the same cycle -> cnt=0, IDLE, out=0. Change lim from 5 to 2 during RUN -> terminal stays 5 until the next ld.
- Free-run up: CW=3, lim=2, div=0 -> cnt wraps 7->0 without stopping, tc pulses once per 8 cycles following the cnt==2 tick, out never falls.
